// File: rtl/i2c_pkg.sv
// Shared I2C command-arbiter types: command/response encodings and arbiter states.
package i2c_pkg;

    localparam int CMD_W = 3;
    localparam int RSP_W = 2;

    typedef enum logic [CMD_W-1:0] {
        I2C_START    = 3'd0,
        I2C_STOP     = 3'd1,
        I2C_WRITE    = 3'd2,
        I2C_READ_ACK = 3'd3,
        I2C_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [RSP_W-1:0] {
        I2C_DONE     = 2'd0,
        I2C_NAK      = 2'd1,
        I2C_ARB_LOST = 2'd2,
        I2C_ERR      = 2'd3
    } i2c_rsp_t;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_ISSUE    = 2'd1,
        ARB_WAIT_RSP = 2'd2,
        ARB_LOCKED   = 2'd3
    } i2c_arb_state_t;

    localparam logic [CMD_W-1:0] CMD_LAST_LEGAL = I2C_READ_NAK;

    function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
        return cmd <= CMD_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: first asserted request scanning upward from ptr+1.
module i2c_rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               grant_valid,
    output logic [IW-1:0]      grant_idx
);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_valid && req[(int'(ptr) + k) % NUM_REQ]) begin
                grant_valid = 1'b1;
                grant_idx   = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master command port between requesters.
// Optional idle-owner watchdog is built when I2C_CMD_ARB_WATCHDOG_EN is defined.
module i2c_cmd_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*CMD_W-1:0]      req_cmd,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [RSP_W-1:0]              rsp_status,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          m_cmd_valid,
    output logic [CMD_W-1:0]              m_cmd,
    output logic [DATA_WIDTH-1:0]         m_data,
    input  logic                          m_cmd_ready,
    input  logic                          m_rsp_valid,
    input  logic [RSP_W-1:0]              m_rsp_status,
    input  logic [DATA_WIDTH-1:0]         m_rsp_data,
    output logic                          busy,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          timeout_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    i2c_arb_state_t   state;
    logic [IW-1:0]    last_owner;
    logic             sel_valid;
    logic [IW-1:0]    sel_idx;
    logic             accept;
    logic [IW-1:0]    acc_idx;
    logic [CMD_W-1:0] acc_cmd;
    logic [DATA_WIDTH-1:0] acc_data;

`ifdef I2C_CMD_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);
    logic [WDW-1:0] wd_count;
    logic           wd_stop;
`endif

    i2c_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req         (req_valid),
        .ptr         (last_owner),
        .grant_valid (sel_valid),
        .grant_idx   (sel_idx)
    );

    // The accept pulse is combinational so capture and req_ready share a cycle; it is held off in reset.
    always_comb begin
        accept  = 1'b0;
        acc_idx = sel_idx;
        if (rst_n) begin
            case (state)
                ARB_IDLE:   accept = sel_valid;
                ARB_LOCKED: begin
                    accept  = req_valid[owner];
                    acc_idx = owner;
                end
                default:    accept = 1'b0;
            endcase
        end
    end

    assign acc_cmd   = req_cmd[int'(acc_idx)*CMD_W +: CMD_W];
    assign acc_data  = req_data[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign req_ready = accept ? (ONE << acc_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ARB_IDLE;
            last_owner  <= IW'(NUM_REQ - 1);
            owner       <= '0;
            busy        <= 1'b0;
            rsp_valid   <= '0;
            rsp_status  <= '0;
            rsp_data    <= '0;
            m_cmd_valid <= 1'b0;
            m_cmd       <= '0;
            m_data      <= '0;
`ifdef I2C_CMD_ARB_WATCHDOG_EN
            wd_count    <= '0;
            wd_stop     <= 1'b0;
            timeout_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= '0;
`ifdef I2C_CMD_ARB_WATCHDOG_EN
            timeout_err <= 1'b0;
`endif
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        if (acc_cmd == I2C_START) begin
                            m_cmd       <= acc_cmd;
                            m_data      <= acc_data;
                            m_cmd_valid <= 1'b1;
                            owner       <= acc_idx;
                            busy        <= 1'b1;
                            state       <= ARB_ISSUE;
                        end else begin
                            rsp_valid  <= ONE << acc_idx;
                            rsp_status <= I2C_ERR;
                            rsp_data   <= '0;
                        end
                    end
                end

                ARB_LOCKED: begin
                    if (accept) begin
`ifdef I2C_CMD_ARB_WATCHDOG_EN
                        wd_count <= '0;
`endif
                        if (cmd_is_legal(acc_cmd)) begin
                            m_cmd       <= acc_cmd;
                            m_data      <= acc_data;
                            m_cmd_valid <= 1'b1;
                            state       <= ARB_ISSUE;
                        end else begin
                            rsp_valid  <= ONE << owner;
                            rsp_status <= I2C_ERR;
                            rsp_data   <= '0;
                        end
                    end
`ifdef I2C_CMD_ARB_WATCHDOG_EN
                    else if (wd_count == WD_LIMIT) begin
                        m_cmd       <= I2C_STOP;
                        m_data      <= '0;
                        m_cmd_valid <= 1'b1;
                        wd_stop     <= 1'b1;
                        wd_count    <= '0;
                        state       <= ARB_ISSUE;
                    end else begin
                        wd_count <= wd_count + 1'b1;
                    end
`endif
                end

                ARB_ISSUE: begin
                    if (m_cmd_ready) begin
                        m_cmd_valid <= 1'b0;
                        state       <= ARB_WAIT_RSP;
                    end
                end

                ARB_WAIT_RSP: begin
                    if (m_rsp_valid) begin
`ifdef I2C_CMD_ARB_WATCHDOG_EN
                        // A watchdog STOP is internal: its completion is reported only via timeout_err.
                        if (wd_stop) begin
                            wd_stop     <= 1'b0;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            last_owner  <= owner;
                            state       <= ARB_IDLE;
                        end else
`endif
                        begin
                            rsp_valid  <= ONE << owner;
                            rsp_status <= m_rsp_status;
                            rsp_data   <= m_rsp_data;
                            if (m_cmd == I2C_STOP || m_rsp_status == I2C_ARB_LOST ||
                                m_rsp_status == I2C_ERR) begin
                                busy       <= 1'b0;
                                last_owner <= owner;
                                state      <= ARB_IDLE;
                            end else begin
                                state <= ARB_LOCKED;
                            end
                        end
                    end
                end

                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifndef I2C_CMD_ARB_WATCHDOG_EN
    assign timeout_err = 1'b0;
`endif

endmodule
